// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1-to-8 word demultiplexer.
package demux_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_SLOTS = 8;
  localparam int unsigned SEL_W   = 3;

  // Pull slot k's word out of the packed out_data bus.
  function automatic logic [DATA_W-1:0] slot_of(
    input logic [N_SLOTS*DATA_W-1:0] bus,
    input int unsigned               k
  );
    return bus[k*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding register for one demux output slot.
module demux_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              free,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q
);

  // Slot can take a new word when empty or when its word leaves this cycle.
  assign free = !valid_q || out_ready;

  // Load has priority over drain so a same-cycle refill keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_d32_s3_buf.sv
// Buffered 1-to-8 demultiplexer: steers each accepted word to one slot or,
// in broadcast mode, to all eight at once.
module demux_d32_s3_buf
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_SLOTS*DATA_W-1:0] out_data,
  output logic [N_SLOTS-1:0]        out_valid,
  input  logic [N_SLOTS-1:0]        out_ready
);

  logic [N_SLOTS-1:0] free;
  logic [N_SLOTS-1:0] load;
  logic               accept;

  // Broadcast needs every slot free; a directed word needs only its target.
  always_comb begin
    in_ready = in_bcast ? (&free) : free[in_sel];
    accept   = in_valid && in_ready;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      load[k] = accept && (in_bcast || (in_sel == SEL_W'(k)));
    end
  end

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .free      (free[k]),
      .data_q    (out_data[k*DATA_W +: DATA_W]),
      .valid_q   (out_valid[k])
    );
  end

endmodule

// File: tb/tb_demux_d32_s3_buf.sv
// Directed self-checking bench for the buffered 1-to-8 demultiplexer.
module tb_demux_d32_s3_buf;
  import demux_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_SLOTS*DATA_W-1:0] out_data;
  logic [N_SLOTS-1:0]        out_valid;
  logic [N_SLOTS-1:0]        out_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [N_SLOTS*DATA_W-1:0] exp_bus;

  demux_d32_s3_buf #(
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_bcast  = 1'b0;
    in_valid  = 1'b0;
    out_ready = '0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 256'(out_valid), 256'h0);
    chk("rst_data", out_data, 256'h0);
    #1 chk("rst_ready_sel", 256'(in_ready), 256'h1);
    in_bcast = 1'b1;
    #1 chk("rst_ready_bcast", 256'(in_ready), 256'h1);
    in_bcast = 1'b0;

    // Single write to slot 5
    in_sel   = 3'd5;
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    #1 chk("wr5_ready", 256'(in_ready), 256'h1);
    tick();
    in_valid = 1'b0;
    chk("wr5_valid", 256'(out_valid), 256'h20);
    exp_bus = '0;
    exp_bus[5*32 +: 32] = 32'hDEAD_BEEF;
    chk("wr5_bus", out_data, exp_bus);
    chk("wr5_helper", 256'(slot_of(out_data, 5)), 256'hDEAD_BEEF);

    // Backpressure on slot 5
    in_data  = 32'h1111_1111;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready_low", 256'(in_ready), 256'h0);
      tick();
      chk("bp_hold", 256'(slot_of(out_data, 5)), 256'hDEAD_BEEF);
    end
    out_ready = 8'h20;
    #1 chk("bp_ready_rise", 256'(in_ready), 256'h1);
    tick();
    in_valid  = 1'b0;
    out_ready = 8'h00;
    chk("bp_replace", 256'(slot_of(out_data, 5)), 256'h1111_1111);
    chk("bp_valid", 256'(out_valid), 256'h20);
    out_ready = 8'h20;
    tick();
    out_ready = 8'h00;
    chk("bp_drained", 256'(out_valid), 256'h0);
    chk("bp_data_kept", 256'(slot_of(out_data, 5)), 256'h1111_1111);

    // Streaming 16 words into slot 2
    out_ready = 8'h04;
    in_sel    = 3'd2;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'(i);
      #1 chk("str_ready", 256'(in_ready), 256'h1);
      tick();
      chk("str_data", 256'(slot_of(out_data, 2)), 256'(i));
      chk("str_valid", 256'(out_valid), 256'h04);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 8'h00;
    chk("str_drained", 256'(out_valid), 256'h0);

    // Broadcast blocked by full slot 7
    in_sel   = 3'd7;
    in_data  = 32'h7777_7777;
    in_valid = 1'b1;
    tick();
    in_bcast = 1'b1;
    in_data  = 32'hA5A5_A5A5;
    exp_bus = '0;
    exp_bus[2*32 +: 32] = 32'h0000_000F;
    exp_bus[5*32 +: 32] = 32'h1111_1111;
    exp_bus[7*32 +: 32] = 32'h7777_7777;
    for (int i = 0; i < 2; i++) begin
      #1 chk("bc_ready_low", 256'(in_ready), 256'h0);
      tick();
      chk("bc_valid_hold", 256'(out_valid), 256'h80);
      chk("bc_bus_hold", out_data, exp_bus);
    end
    out_ready = 8'h80;
    #1 chk("bc_ready_rise", 256'(in_ready), 256'h1);
    tick();
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = 8'h00;
    chk("bc_valid_all", 256'(out_valid), 256'hFF);
    chk("bc_bus_all", out_data, {8{32'hA5A5_A5A5}});

    // Reset mid-operation with a word presented
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'd0;
    in_data  = 32'h1234_5678;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mrst_valid", 256'(out_valid), 256'h0);
    chk("mrst_data", out_data, 256'h0);

    // Independence around stalled slot 3
    in_sel   = 3'd3;
    in_data  = 32'h3333_3333;
    in_valid = 1'b1;
    tick();
    #1 chk("ind_ready3_low", 256'(in_ready), 256'h0);
    in_sel  = 3'd0; in_data = 32'h0000_00A0;
    #1 chk("ind_ready0", 256'(in_ready), 256'h1);
    tick();
    in_sel  = 3'd1; in_data = 32'h0000_00A1;
    #1 chk("ind_ready1", 256'(in_ready), 256'h1);
    tick();
    in_sel  = 3'd4; in_data = 32'h0000_00A4;
    #1 chk("ind_ready4", 256'(in_ready), 256'h1);
    tick();
    in_valid = 1'b0;
    chk("ind_valid", 256'(out_valid), 256'h1B);
    exp_bus = '0;
    exp_bus[0*32 +: 32] = 32'h0000_00A0;
    exp_bus[1*32 +: 32] = 32'h0000_00A1;
    exp_bus[3*32 +: 32] = 32'h3333_3333;
    exp_bus[4*32 +: 32] = 32'h0000_00A4;
    chk("ind_bus", out_data, exp_bus);

    // Drain request on an empty slot must not disturb anything
    out_ready = 8'h04;
    tick();
    out_ready = 8'h00;
    chk("empty_drain_valid", 256'(out_valid), 256'h1B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_d32_s3_buf.md
# demux_d32_s3_buf

Buffered 1-to-8 demultiplexer for 32-bit words, the distribution-side counterpart of the 8:1 read-side word selectors in the datapath. It accepts one word per cycle over a valid/ready handshake and steers it to one of eight output slots, or to all eight in broadcast mode. Each slot holds the word in a single-entry register until that slot's consumer takes it. It sits between a single producer (e.g. writeback or a bus response path) and eight independent consumers.

## Interface
Parameters:
- DATA_W, 32, word width; the block is specified and verified at 32 only.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  word to distribute.
- in_sel  in  3  target slot index 0..7; ignored when in_bcast=1.
- in_bcast  in  1  broadcast: write in_data to all 8 slots.
- in_valid  in  1  producer has a word; qualified by in_sel and in_bcast.
- in_ready  out  1  block accepts the word this cycle.
- out_data  out  256  slot k data on bits [32k+31:32k].
- out_valid  out  8  slot k holds an undelivered word.
- out_ready  in  8  consumer k takes slot k's word this cycle.

## Operation
- Per-slot state: data_q[k] (32 b) and valid_q[k]. Outputs are driven directly: out_data = data_q, out_valid = valid_q.
- free[k] = !valid_q[k] || out_ready[k]. A slot can load in the same cycle it drains.
- in_ready = in_bcast ? &free : free[in_sel]. This is combinational from out_ready, in_sel and in_bcast.
- accept = in_valid && in_ready.
- load[k] = accept && (in_bcast || in_sel == k).
- Next state per slot:
  - load[k]: data_q <= in_data, valid_q <= 1.
  - else if valid_q[k] && out_ready[k]: valid_q <= 0, data_q holds.
  - else: hold.
- out_ready[k] while valid_q[k]=0 has no effect.
- Producer rules:
  - in_data, in_sel and in_bcast must stay stable while in_valid=1 and in_ready=0.
  - The block never drops or duplicates a word.
- Broadcast is all-or-nothing. No slot loads unless all eight are free in that cycle.
- Slots are independent. A stalled slot blocks only words addressed to it, plus broadcasts.

## Timing
- Reset (rst=1 at a rising edge): all valid_q=0 and all data_q=0. in_ready is then 1 for any sel and also for bcast.
- Reset takes priority over load and drain in the same cycle. A word presented during reset is not accepted.
- Latency: a word accepted at edge N appears on out_data/out_valid immediately after edge N.
- Throughput:
  - 1 word per cycle into a given slot, provided its consumer holds out_ready=1 continuously.
  - 1 word per cycle overall across different slots.
- Full slot with out_ready[k]=0: in_ready=0 for sel=k and for bcast. Contents hold until drained.
- Simultaneous load and drain of slot k: the new word replaces the old one and valid stays 1. The old word counts as delivered.
- out_data for an invalid slot retains the last delivered word. Consumers must qualify with out_valid.

## Structure
- Shared package demux_pkg:
  - DATA_W = 32.
  - N_SLOTS = 8.
  - SEL_W = 3.
  - A helper that extracts slot k's field from the packed 256-bit bus, for benches and consumers.
- Sub-module demux_slot, instantiated 8 times:
  - Inputs: clk, rst, load, in_data, out_ready.
  - Outputs: free, data_q, valid_q.
- Top level holds only the free/in_ready/load decode.

## Test plan
- Reset then single write: rst 2 cycles; in_sel=5, in_data=32'hDEAD_BEEF, in_valid=1, out_ready=0 → in_ready=1; after the edge out_valid=8'b0010_0000 and slot 5 reads DEAD_BEEF; all other slots read 0.
- Backpressure: slot 5 full with out_ready[5]=0, present in_sel=5, in_data=32'h1111_1111 → in_ready=0 for 3 cycles and slot 5 stays DEAD_BEEF; raise out_ready[5] → in_ready=1 same cycle and slot 5 reads 1111_1111 after the edge with valid still 1.
- Streaming: in_sel=2, in_data 0,1,2,…,15 on consecutive cycles with out_ready[2]=1 → 16 accepts in 16 cycles; slot 2 delivers 0..15 in order with no gaps.
- Broadcast blocking: slot 7 full with out_ready[7]=0, in_bcast=1, in_data=32'hA5A5_A5A5 → in_ready=0 and no slot changes; release out_ready[7] → all 8 slots read A5A5_A5A5 with out_valid=8'hFF.
- Independence: slot 3 stalled full; words to slots 0,1,4 in consecutive cycles → all three accepted back-to-back; slot 3 contents unchanged.
- Reset mid-operation: out_valid=8'hFF, assert rst with in_valid=1 and in_sel=0 → after the edge out_valid=0 and all data_q=0; the presented word is not loaded.
